// File: rtl/tiny_dnn_pkg.sv
// tiny_dnn_pkg: shared widths and encodings for the 2x2 pool/unpool stages.
package tiny_dnn_pkg;
    localparam int ADDR_W = 16;
    localparam int OW_W   = 5;
    // {row, col} bit mapping matches the forward pool's 2-bit argmax code
    typedef enum logic [1:0] {B_TL, B_TR, B_BL, B_BR} beat_e;
    typedef enum logic {S_IDLE, S_EMIT} state_e;
endpackage

// File: rtl/tiny_dnn_pool_addr_gen.sv
// tiny_dnn_pool_addr_gen: 2x2 window-base counter shared by the forward pool and the unpool.
module tiny_dnn_pool_addr_gen
    import tiny_dnn_pkg::*;
#(
    parameter int AW  = ADDR_W,
    parameter int OWW = OW_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    input  logic [OWW-1:0] ow,
    output logic [AW-2:0]  pa,
    output logic [OWW-1:0] px
);
    logic wrap;
    assign wrap = ({1'b0, px} + (OWW+1)'(1)) == {1'b0, ow};
    // at the end of a pooled row, skip the odd input row the windows already covered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= '0;
            px <= '0;
        end else if (clear) begin
            pa <= '0;
            px <= '0;
        end else if (step) begin
            pa <= pa + (AW-1)'(1) + (wrap ? (AW-1)'(ow) : '0);
            px <= wrap ? '0 : px + 1'b1;
        end
    end
endmodule

// File: rtl/tiny_dnn_unpool.sv
// tiny_dnn_unpool: scatters each pooled gradient over its 2x2 input window as four write beats,
// the gradient landing on the recorded argmax address and 0.0 on the other three.
module tiny_dnn_unpool
    import tiny_dnn_pkg::*;
#(
    parameter int AW  = ADDR_W,
    parameter int OWW = OW_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           unpool,
    input  logic           u_fin,
    input  logic [OWW-1:0] ow,
    input  logic           in_valid,
    output logic           in_ready,
    input  real            gi,
    input  logic [AW-1:0]  pp,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  wa,
    output real            wd,
    output logic           unpool_busy,
    output logic           idx_err
);
    state_e        state, state_n;
    beat_e         beat, beat_n;
    real           g_r;
    logic [AW-1:0] pp_r;
    logic [AW-2:0] base_r, pa, row_b;
    logic [OWW-1:0] px;
    logic          clr, accept, fire, last, match;

    assign clr         = ~unpool | u_fin;
    assign out_valid   = state == S_EMIT;
    assign unpool_busy = state == S_EMIT;
    assign fire        = out_valid & out_ready;
    assign last        = fire & (beat == B_BR);
    // reload on the final beat's handshake keeps elements back-to-back
    assign in_ready    = unpool & ~u_fin & (ow != '0) & ((state == S_IDLE) | last);
    assign accept      = in_valid & in_ready;
    assign row_b       = base_r + (AW-1)'(ow);
    assign wa          = {beat[1] ? row_b : base_r, beat[0]};
    assign wd          = (wa == pp_r) ? g_r : 0.0;
    assign match       = (pp_r[AW-1:1] == base_r) | (pp_r[AW-1:1] == row_b);

    tiny_dnn_pool_addr_gen #(.AW(AW), .OWW(OWW)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clr),
        .step  (accept),
        .ow    (ow),
        .pa    (pa),
        .px    (px)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            beat  <= B_TL;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        if (clr) begin
            state_n = S_IDLE;
            beat_n  = B_TL;
        end else if (accept) begin
            state_n = S_EMIT;
            beat_n  = B_TL;
        end else if (fire) begin
            state_n = (beat == B_BR) ? S_IDLE : S_EMIT;
            beat_n  = beat_e'(beat + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_r     <= 0.0;
            pp_r    <= '0;
            base_r  <= '0;
            idx_err <= 1'b0;
        end else begin
            if (accept) begin
                g_r    <= gi;
                pp_r   <= pp;
                base_r <= pa;
            end
            idx_err <= clr ? 1'b0 : idx_err | (last & ~match);
        end
    end
endmodule

// File: tb/tb_tiny_dnn_unpool.sv
// tb_tiny_dnn_unpool: directed checks of beat order, addressing, stalls, clears and error flag.
module tb_tiny_dnn_unpool;
    logic        clk = 1'b0, rst_n = 1'b1, unpool = 1'b0, u_fin = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0]  ow = 5'd2;
    logic [15:0] pp = '0;
    real         gi = 0.0;
    logic        in_ready, out_valid, unpool_busy, idx_err;
    logic [15:0] wa;
    real         wd;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    tiny_dnn_unpool dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .unpool      (unpool),
        .u_fin       (u_fin),
        .ow          (ow),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gi          (gi),
        .pp          (pp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wa          (wa),
        .wd          (wd),
        .unpool_busy (unpool_busy),
        .idx_err     (idx_err)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input real obs, input real exp);
        n_chk++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    // four beats of one element; the next offer is applied once this element is latched
    task automatic beats(input logic [15:0] a0, a1, a2, a3, input int h, input real g,
                         input logic nv, input real ng, input logic [15:0] npp);
        logic [15:0] w [4];
        w = '{a0, a1, a2, a3};
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("wa", {16'd0, wa}, {16'd0, w[b]});
            chkr("wd", wd, (b == h) ? g : 0.0);
            chk("in_ready", {31'd0, in_ready}, {31'd0, b == 3});
            if (b == 0) begin
                in_valid = nv;
                gi = ng;
                pp = npp;
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wa", {16'd0, wa}, 32'd0);
        chkr("rst_wd", wd, 0.0);
        chk("rst_busy", {31'd0, unpool_busy}, 32'd0);
        chk("rst_idx_err", {31'd0, idx_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        unpool = 1'b1;
        in_valid = 1'b1; gi = 1.5; pp = 16'h0001;
        #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        beats(16'd0, 16'd1, 16'd4, 16'd5, 1, 1.5, 1'b1, -2.0, 16'h0006);
        beats(16'd2, 16'd3, 16'd6, 16'd7, 2, -2.0, 1'b1, 3.0, 16'h0009);
        beats(16'd8, 16'd9, 16'd12, 16'd13, 1, 3.0, 1'b1, 0.5, 16'h000E);
        beats(16'd10, 16'd11, 16'd14, 16'd15, 2, 0.5, 1'b0, 0.0, 16'h0000);
        tick();
        chk("idle_after_stream", {31'd0, out_valid}, 32'd0);
        chk("idx_err_clean", {31'd0, idx_err}, 32'd0);
        u_fin = 1'b1; in_valid = 1'b1; gi = 7.0; pp = 16'h0000;
        #1 chk("fin_blocks_ready", {31'd0, in_ready}, 32'd0);
        tick();
        u_fin = 1'b0; in_valid = 1'b0;
        chk("fin_no_accept", {31'd0, unpool_busy}, 32'd0);
        in_valid = 1'b1; gi = 9.0; pp = 16'h00FF;
        beats(16'd0, 16'd1, 16'd4, 16'd5, -1, 9.0, 1'b0, 0.0, 16'h0000);
        tick();
        chk("idx_err_set", {31'd0, idx_err}, 32'd1);
        in_valid = 1'b1; gi = 2.5; pp = 16'h0003;
        tick();
        in_valid = 1'b0;
        chk("st_b0_wa", {16'd0, wa}, 32'd2);
        chkr("st_b0_wd", wd, 0.0);
        tick();
        chk("st_b1_wa", {16'd0, wa}, 32'd3);
        chkr("st_b1_wd", wd, 2.5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_wa", {16'd0, wa}, 32'd3);
            chkr("stall_wd", wd, 2.5);
        end
        out_ready = 1'b1;
        tick();
        chk("st_b2_wa", {16'd0, wa}, 32'd6);
        tick();
        chk("st_b3_wa", {16'd0, wa}, 32'd7);
        chkr("st_b3_wd", wd, 0.0);
        tick();
        chk("st_done", {31'd0, out_valid}, 32'd0);
        chk("idx_err_sticky", {31'd0, idx_err}, 32'd1);
        u_fin = 1'b1;
        tick();
        u_fin = 1'b0;
        chk("idx_err_fin_clr", {31'd0, idx_err}, 32'd0);
        in_valid = 1'b1; gi = 1.0; pp = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("ab_b0_wa", {16'd0, wa}, 32'd0);
        chkr("ab_b0_wd", wd, 1.0);
        tick();
        chk("ab_b1_wa", {16'd0, wa}, 32'd1);
        tick();
        chk("ab_b2_wa", {16'd0, wa}, 32'd4);
        u_fin = 1'b1;
        tick();
        u_fin = 1'b0;
        chk("ab_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ab_busy", {31'd0, unpool_busy}, 32'd0);
        in_valid = 1'b1; gi = 4.0; pp = 16'h0005;
        beats(16'd0, 16'd1, 16'd4, 16'd5, 3, 4.0, 1'b0, 0.0, 16'h0000);
        tick();
        in_valid = 1'b1; gi = 6.0; pp = 16'h0003;
        tick();
        in_valid = 1'b0;
        chk("ar_b0_wa", {16'd0, wa}, 32'd2);
        tick();
        chk("ar_b1_busy", {31'd0, unpool_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_wa", {16'd0, wa}, 32'd0);
        chkr("ar_wd", wd, 0.0);
        chk("ar_busy", {31'd0, unpool_busy}, 32'd0);
        chk("ar_idx_err", {31'd0, idx_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        ow = 5'd0; in_valid = 1'b1;
        #1 chk("ow0_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ow0_busy", {31'd0, unpool_busy}, 32'd0);
        chk("ow0_idx_err", {31'd0, idx_err}, 32'd0);
        in_valid = 1'b0; ow = 5'd2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tiny_dnn_unpool.md
Name: tiny_dnn_unpool

Overview:
Backward-pass counterpart of the 2x2 max-pool stage. Consumes a stream of pooled gradients, each tagged with the 16-bit argmax input address the forward pool recorded. For each gradient it emits four write beats that cover the 2x2 input window: the gradient goes to the argmax address and 0.0 goes to the other three. Sits between the backward gradient source and the input-feature-map gradient buffer.

Parameters:
AW, 16, address width of pp and wa; the window-base counter is AW-1 bits.
OWW, 5, width of the pooled-row-width input ow.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
unpool  in  1  mode enable; low synchronously clears all state
u_fin  in  1  end-of-plane pulse; clears counters and aborts the current element
ow  in  OWW  pooled row width; 1..31 legal
in_valid  in  1  gradient/index pair offered
in_ready  out  1  pair accepted on this edge when in_valid is also high
gi  in  real  pooled gradient value
pp  in  AW  argmax input address, format {row_addr, col_bit}
out_valid  out  1  write beat valid
out_ready  in  1  sink accepts the beat
wa  out  AW  write address
wd  out  real  write data
unpool_busy  out  1  element in flight (state EMIT)
idx_err  out  1  sticky flag: an element's pp matched none of its 4 window addresses

Behaviour:
- Reset (rst_n low, async): state IDLE, beat=0, pa=0, px=0, out_valid=0, wa=0, wd=0.0, idx_err=0, unpool_busy=0.
- Window counter (mirror of the forward pool): pa[AW-1:1], px[OWW-1:0]. Counter updates on each accept. If px+1==ow, then pa<=pa+1+ow and px<=0. Otherwise pa<=pa+1 and px<=px+1. pa wraps modulo 2^(AW-1).
- On accept: latch g_r<=gi, pp_r<=pp, base_r<=pa (the value before the increment).
- FSM IDLE/EMIT, beat counter 0..3.
  - IDLE: in_ready = unpool & ~u_fin & (ow!=0). Accept moves to EMIT with beat=0.
  - EMIT: out_valid=1. Beat addresses in order: 0 {base_r,0}; 1 {base_r,1}; 2 {base_r+ow,0}; 3 {base_r+ow,1}.
  - wd = (wa==pp_r) ? g_r : 0.0.
  - The beat advances only when out_valid & out_ready. wa and wd stay stable while stalled.
  - Beat 3 handshake: if in_ready is also taken (in_ready = out_ready & unpool & ~u_fin & ow!=0 in this beat), reload and stay in EMIT at beat=0. This gives back-to-back elements with no bubble. Otherwise go to IDLE.
- Latency: accept at edge N, so beat 0 is valid after edge N. Minimum 4 cycles per element; sustained throughput is 1 element per 4 cycles.
- idx_err: set at the beat-3 handshake if no beat of the element matched pp_r. Cleared by ~unpool or u_fin. Never cleared by a later good element.
- u_fin high:
  - Next edge: pa=0, px=0, state IDLE, out_valid=0. Any in-flight beats are dropped.
  - in_ready is low in that cycle, so u_fin wins over a simultaneous in_valid.
- unpool low: same clear as u_fin, plus idx_err=0. in_ready stays low.
- ow==0: in_ready stays low and no error is raised. A change of ow mid-plane is not supported.
- unpool_busy = (state==EMIT).

Decomposition:
- Shared package tiny_dnn_pkg:
  - address width constant (16).
  - ow width constant (5).
  - beat-index enum {B_TL, B_TR, B_BL, B_BR}; this encoding matches the forward pool's 2-bit argmax code via bit mapping {row, col}.
  - FSM state enum {S_IDLE, S_EMIT}.
- One natural sub-module: tiny_dnn_pool_addr_gen. It holds the pa/px window counter and is shared with the forward pool, with clear, step and ow ports.

Test Plan:
- ow=2, unpool=1, out_ready=1. Accept gi=1.5, pp=0x0001 -> beats wa=0,1,4,5 with wd=0,1.5,0,0; idx_err=0.
- Second element back-to-back, gi=-2.0, pp=0x0006 (base pa=1) -> wa=2,3,6,7 with wd=0,0,-2.0,0. No idle cycle between elements; in_ready high on beat 3 only.
- ow=2, 3rd element (px wrap): pa jumps to 4 -> wa=8,9,12,13. Then 4th element -> wa=10,11,14,15.
- out_ready low for 3 cycles on beat 1 -> wa and wd held stable; total element time 7 cycles; no beat lost or duplicated.
- pp=0x00FF for base 0 -> all wd=0.0; idx_err=1 after beat 3. It stays 1 through a good element and clears on a u_fin pulse.
- u_fin asserted during beat 2 -> out_valid=0 on the next edge, counter zero. Next accept emits wa=0,1,4,5.
- rst_n low asynchronously mid-EMIT -> all outputs reach reset values before the next clk edge.
